// File: rtl/uart_rx_controller.sv
// UART receive-side controller: 16x baud tick generator, rx_doneTick capture
// through a synchronizer, and a first-word fall-through byte FIFO with overrun/irq.
module uart_rx_controller #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_enable,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          s_tick,
    input  logic                          rx_doneTick,
    input  logic [7:0]                    rx_dataOut,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Tick generator state
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             s_tick_q, s_tick_d;

    // Capture synchronizer, delayed copy and post-reset priming shift register
    logic             sync1_q, sync2_q, sync_dly_q;
    logic [2:0]       prime_q, prime_d;
    logic             rise_det;

    // FIFO state
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             irq_q, irq_d;

    logic             push_req, do_push, do_pop, fifo_full;

    // Edges are only trusted once the delayed copy holds a real sample, so a
    // strobe already high at reset release never looks like a new rise.
    assign rise_det  = sync2_q & ~sync_dly_q & prime_q[2];
    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign push_req  = rise_det & rx_enable;
    assign do_pop    = rd_en & rx_valid_q;
    assign do_push   = push_req & (~fifo_full | do_pop);

    always_comb begin
        div_cnt_d  = '0;
        s_tick_d   = 1'b0;
        prime_d    = {prime_q[1:0], 1'b1};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        rd_data_d  = 8'h00;
        rx_valid_d = 1'b0;
        irq_d      = 1'b0;

        if (rx_enable) begin
            if (div_cnt_q >= baud_div) begin
                s_tick_d = 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A new overrun wins over a simultaneous clear.
        if (push_req && fifo_full && !do_pop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        // Next head: the byte being written when it lands at the new read pointer.
        rx_valid_d = (count_d != '0);
        if (rx_valid_d) begin
            if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                rd_data_d = rx_dataOut;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end
        irq_d = rx_valid_d | overrun_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            s_tick_q   <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync_dly_q <= 1'b0;
            prime_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            s_tick_q   <= s_tick_d;
            sync1_q    <= rx_doneTick;
            sync2_q    <= sync1_q;
            sync_dly_q <= sync2_q;
            prime_q    <= prime_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            irq_q      <= irq_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= rx_dataOut;
        end
    end

    assign s_tick     = s_tick_q;
    assign rd_data    = rd_data_q;
    assign rx_valid   = rx_valid_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: expected popped bytes go into a
// scoreboard queue; a negedge monitor compares every accepted pop.
module tb_uart_rx_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_enable;
    logic [15:0] baud_div;
    logic       s_tick;
    logic       rx_doneTick;
    logic [7:0] rx_dataOut;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       clr_overrun;
    logic       irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    uart_rx_controller #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_enable   (rx_enable),
        .baud_div    (baud_div),
        .s_tick      (s_tick),
        .rx_doneTick (rx_doneTick),
        .rx_dataOut  (rx_dataOut),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rx_valid    (rx_valid),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One rx_doneTick pulse of len cycles followed by enough idle for the edge detector.
    task automatic push_byte(input logic [7:0] b, input int len, input bit accepted);
        if (accepted) exp_q.push_back(b);
        rx_dataOut  = b;
        rx_doneTick = 1'b1;
        repeat (len) tick();
        rx_doneTick = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) tick();
        rd_en = 1'b0;
    endtask

    // Scoreboard monitor: each accepted pop must present the oldest expected byte.
    always @(negedge clk) begin
        if (!rst && rd_en && rx_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none at %0t", rd_data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", rd_data, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rx_enable = 1'b0; baud_div = 16'd3; rx_doneTick = 1'b0;
        rx_dataOut = 8'h00; rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (2) tick();
        chk("rst_s_tick", 32'(s_tick), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_irq", 32'(irq), 0);
        rst = 1'b0;
        repeat (5) tick();

        // Tick generator: period 4 with baud_div=3
        rx_enable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk($sformatf("tick_c%0d", c), 32'(s_tick), 32'((c % 4) == 0));
        end
        repeat (2) tick();
        rx_enable = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("tick_disabled", 32'(s_tick), 0);
        end
        rx_enable = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("tick_restart_c%0d", c), 32'(s_tick), 32'(c == 4));
        end
        baud_div = 16'd0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("tick_div0", 32'(s_tick), 1);
        end
        rx_enable = 1'b0;
        tick();
        baud_div = 16'd7;
        rx_enable = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("tick_div7", 32'(s_tick), 0);
        end
        baud_div = 16'd2;
        for (int c = 6; c <= 9; c++) begin
            tick();
            chk($sformatf("tick_shrink_c%0d", c), 32'(s_tick), 32'(c == 6 || c == 9));
        end
        baud_div = 16'd3;

        // Empty-FIFO latency of three edges
        exp_q.push_back(8'hA5);
        rx_dataOut = 8'hA5; rx_doneTick = 1'b1;
        tick(); chk("lat_e1_valid", 32'(rx_valid), 0);
        tick(); chk("lat_e2_valid", 32'(rx_valid), 0);
        tick();
        chk("lat_e3_valid", 32'(rx_valid), 1);
        chk("lat_e3_data", 32'(rd_data), 32'h A5);
        chk("lat_e3_count", 32'(fifo_count), 1);
        chk("lat_e3_irq", 32'(irq), 1);
        rx_doneTick = 1'b0;
        repeat (3) tick();
        pop_n(1);
        chk("pop_valid", 32'(rx_valid), 0);
        chk("pop_rd_data", 32'(rd_data), 0);
        chk("pop_count", 32'(fifo_count), 0);
        chk("pop_irq", 32'(irq), 0);

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) push_byte(8'(i), 1, i <= 4);
        chk("ovf_count", 32'(fifo_count), 4);
        chk("ovf_flag", 32'(overrun), 1);
        chk("ovf_head", 32'(rd_data), 1);
        pop_n(4);
        chk("ovf_drain_count", 32'(fifo_count), 0);
        chk("ovf_sticky", 32'(overrun), 1);
        chk("ovf_irq", 32'(irq), 1);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        chk("clr_overrun", 32'(overrun), 0);
        chk("clr_irq", 32'(irq), 0);

        // Full FIFO with pop coincident with push
        push_byte(8'h11, 1, 1'b1);
        push_byte(8'h22, 1, 1'b1);
        push_byte(8'h33, 1, 1'b1);
        push_byte(8'h44, 1, 1'b1);
        chk("full_count", 32'(fifo_count), 4);
        exp_q.push_back(8'h55);
        rx_dataOut = 8'h55; rx_doneTick = 1'b1;
        repeat (2) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rx_doneTick = 1'b0;
        chk("pushpop_count", 32'(fifo_count), 4);
        chk("pushpop_overrun", 32'(overrun), 0);
        chk("pushpop_head", 32'(rd_data), 32'h22);
        repeat (3) tick();
        pop_n(4);
        chk("pushpop_drain", 32'(fifo_count), 0);

        // Long strobe gives exactly one push; pops on empty are ignored
        push_byte(8'h66, 10, 1'b1);
        chk("long_count", 32'(fifo_count), 1);
        pop_n(1);
        pop_n(2);
        chk("empty_pop_count", 32'(fifo_count), 0);
        chk("empty_pop_valid", 32'(rx_valid), 0);
        chk("empty_pop_data", 32'(rd_data), 0);

        // Edges while disabled are discarded, contents kept
        push_byte(8'h77, 1, 1'b1);
        rx_enable = 1'b0;
        push_byte(8'h88, 1, 1'b0);
        chk("dis_count", 32'(fifo_count), 1);
        chk("dis_head", 32'(rd_data), 32'h77);
        rx_enable = 1'b1;
        pop_n(1);

        // Reset with bytes queued and strobe held high
        push_byte(8'hA1, 1, 1'b1);
        push_byte(8'hA2, 1, 1'b1);
        push_byte(8'hA3, 1, 1'b1);
        chk("pre_rst_count", 32'(fifo_count), 3);
        rx_dataOut = 8'hB0; rx_doneTick = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_valid", 32'(rx_valid), 0);
        chk("arst_rd_data", 32'(rd_data), 0);
        chk("arst_irq", 32'(irq), 0);
        chk("arst_s_tick", 32'(s_tick), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("held_strobe_count", 32'(fifo_count), 0);
        rx_doneTick = 1'b0;
        repeat (4) tick();
        push_byte(8'hC3, 1, 1'b1);
        chk("post_rst_count", 32'(fifo_count), 1);
        chk("post_rst_head", 32'(rd_data), 32'hC3);
        pop_n(1);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
